// File: rtl/wb_daq_csr_array_pkg.sv
// rtl/wb_daq_csr_array_pkg.sv - register map constants shared by the DAQ CSR block
// Holds byte offsets, the ID word and the CONTROL bit positions.
package wb_daq_csr_array_pkg;

    localparam logic [7:0] OFF_CONTROL    = 8'h00;
    localparam logic [7:0] OFF_IRQ_STATUS = 8'h04;
    localparam logic [7:0] OFF_IRQ_ENABLE = 8'h08;
    localparam logic [7:0] OFF_ID         = 8'h0C;
    localparam logic [7:0] OFF_CHAN_BASE  = 8'h10;
    localparam logic [7:0] CHAN_STRIDE    = 8'h10;

    localparam logic [7:0] CH_OFF_ADDRESS = 8'h0;
    localparam logic [7:0] CH_OFF_CONTROL = 8'h4;
    localparam logic [7:0] CH_OFF_STATUS  = 8'h8;
    localparam logic [7:0] CH_OFF_RSVD    = 8'hC;

    localparam logic [15:0] ID_MAGIC = 16'hDA02;

    localparam int CTRL_IRQ_EN_BIT  = 0;
    localparam int CHCTRL_START_BIT = 0;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CONTROL,
        REG_IRQ_STATUS,
        REG_IRQ_ENABLE,
        REG_ID,
        REG_CH_ADDR,
        REG_CH_CTRL,
        REG_CH_STATUS
    } reg_sel_e;

    function automatic logic [31:0] id_value(input int num_ch);
        return {ID_MAGIC, 8'd0, num_ch[7:0]};
    endfunction

endpackage

// File: rtl/wb_daq_csr_array_if.sv
// rtl/wb_daq_csr_array_if.sv - Wishbone classic slave bus bundle for the DAQ CSR block
// The slave modport is the register block side, master is the bus initiator.
interface wb_daq_csr_array_if #(
    parameter int dw = 32,
    parameter int aw = 8
);
    logic [aw-1:0] wb_adr_i;
    logic [dw-1:0] wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [2:0]    wb_cti_i;
    logic [1:0]    wb_bte_i;
    logic [dw-1:0] wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          wb_rty_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

endinterface

// File: rtl/wb_daq_csr_byte_reg.sv
// rtl/wb_daq_csr_byte_reg.sv - one byte-enabled read/write register
// WMASK marks the bits that are actually stored; masked-off bits stay zero.
module wb_daq_csr_byte_reg #(
    parameter int            dw    = 32,
    parameter logic [dw-1:0] WMASK = '1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_we,
    input  logic [dw/8-1:0] i_sel,
    input  logic [dw-1:0]   i_dat,
    output logic [dw-1:0]   o_q
);

    logic [dw-1:0] r_q;
    logic [dw-1:0] w_bits;

    always_comb begin
        w_bits = '0;
        for (int b = 0; b < dw/8; b++) begin
            w_bits[b*8 +: 8] = {8{i_sel[b]}};
        end
        w_bits = w_bits & WMASK;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= (r_q & ~w_bits) | (i_dat & w_bits);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/wb_daq_csr_array.sv
// rtl/wb_daq_csr_array.sv - Wishbone CSR array for a multi-channel DAQ engine
// Define WB_DAQ_CSR_ERR_EN to answer unmapped/reserved/RO-write accesses with wb_err_o.
module wb_daq_csr_array
    import wb_daq_csr_array_pkg::*;
#(
    parameter int dw           = 32,
    parameter int aw           = 8,
    parameter int NUM_CHANNELS = 4
) (
    input  logic                       wb_clk,
    input  logic                       wb_rst,
    wb_daq_csr_array_if.slave          wb,
    output logic [dw-1:0]              daq_control_reg,
    output logic [NUM_CHANNELS*dw-1:0] daq_channel_address_reg,
    output logic [NUM_CHANNELS*dw-1:0] daq_channel_control_reg,
    output logic [NUM_CHANNELS-1:0]    daq_channel_start,
    input  logic [NUM_CHANNELS*dw-1:0] daq_channel_status_reg,
    input  logic [NUM_CHANNELS-1:0]    daq_channel_event,
    output logic                       interrupt
);

    localparam logic [dw-1:0] FULL_WMASK    = '1;
    localparam logic [dw-1:0] CH_CTRL_WMASK = ~(dw'(1));
    localparam logic [dw-1:0] IRQ_EN_WMASK  = dw'((1 << NUM_CHANNELS) - 1);

    logic [aw-5:0]           w_blk;
    logic [2:0]              w_ch;
    reg_sel_e                w_sel;
    logic                    w_access;
    logic                    w_wr;
    logic                    w_bad;
    logic [dw-1:0]           w_rdata;
    logic [dw-1:0]           w_irq_en;
    logic [NUM_CHANNELS-1:0] w_w1c;
    logic [NUM_CHANNELS-1:0] w_start;
    logic [dw-1:0]           w_ch_addr [8];
    logic [dw-1:0]           w_ch_ctrl [8];
    logic [dw-1:0]           w_ch_stat [8];
    logic                    w_unused;

    logic                    r_ack;
    logic                    r_err;
    logic [dw-1:0]           r_dat;
    logic                    r_interrupt;
    logic [NUM_CHANNELS-1:0] r_irq_status;
    logic [NUM_CHANNELS-1:0] r_start;

    // Each 16-byte block is one page: block 0 holds globals, block n+1 holds channel n.
    assign w_blk = wb.wb_adr_i[aw-1:4];
    assign w_ch  = 3'(w_blk) - 3'd1;

    always_comb begin
        w_sel = REG_NONE;
        if (w_blk == '0) begin
            case (wb.wb_adr_i[3:2])
                OFF_CONTROL[3:2]:    w_sel = REG_CONTROL;
                OFF_IRQ_STATUS[3:2]: w_sel = REG_IRQ_STATUS;
                OFF_IRQ_ENABLE[3:2]: w_sel = REG_IRQ_ENABLE;
                OFF_ID[3:2]:         w_sel = REG_ID;
                default:             w_sel = REG_NONE;
            endcase
        end else if (w_blk <= NUM_CHANNELS[aw-5:0]) begin
            case (wb.wb_adr_i[3:2])
                CH_OFF_ADDRESS[3:2]: w_sel = REG_CH_ADDR;
                CH_OFF_CONTROL[3:2]: w_sel = REG_CH_CTRL;
                CH_OFF_STATUS[3:2]:  w_sel = REG_CH_STATUS;
                default:             w_sel = REG_NONE;
            endcase
        end
    end

`ifdef WB_DAQ_CSR_ERR_EN
    assign w_bad = (w_sel == REG_NONE) ||
                   (wb.wb_we_i && ((w_sel == REG_ID) || (w_sel == REG_CH_STATUS)));
`else
    assign w_bad = 1'b0;
`endif

    // Blocking on the previous cycle's ack/err makes a held strobe ack every other cycle.
    assign w_access = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack & ~r_err;
    assign w_wr     = w_access & wb.wb_we_i & ~w_bad;
    assign w_w1c    = (w_wr && (w_sel == REG_IRQ_STATUS) && wb.wb_sel_i[0]) ?
                      wb.wb_dat_i[NUM_CHANNELS-1:0] : '0;

    wb_daq_csr_byte_reg #(.dw(dw), .WMASK(FULL_WMASK)) u_control (
        .i_clk (wb_clk),
        .i_rst (wb_rst),
        .i_we  (w_wr && (w_sel == REG_CONTROL)),
        .i_sel (wb.wb_sel_i),
        .i_dat (wb.wb_dat_i),
        .o_q   (daq_control_reg)
    );

    wb_daq_csr_byte_reg #(.dw(dw), .WMASK(IRQ_EN_WMASK)) u_irq_enable (
        .i_clk (wb_clk),
        .i_rst (wb_rst),
        .i_we  (w_wr && (w_sel == REG_IRQ_ENABLE)),
        .i_sel (wb.wb_sel_i),
        .i_dat (wb.wb_dat_i),
        .o_q   (w_irq_en)
    );

    genvar n;
    generate
        for (n = 0; n < 8; n++) begin : g_ch
            if (n < NUM_CHANNELS) begin : g_on
                logic w_addr_we;
                logic w_ctrl_we;

                assign w_addr_we = w_wr && (w_sel == REG_CH_ADDR) && (w_ch == 3'(n));
                assign w_ctrl_we = w_wr && (w_sel == REG_CH_CTRL) && (w_ch == 3'(n));

                wb_daq_csr_byte_reg #(.dw(dw), .WMASK(FULL_WMASK)) u_addr (
                    .i_clk (wb_clk),
                    .i_rst (wb_rst),
                    .i_we  (w_addr_we),
                    .i_sel (wb.wb_sel_i),
                    .i_dat (wb.wb_dat_i),
                    .o_q   (daq_channel_address_reg[n*dw +: dw])
                );

                // The start bit is never stored; it only launches a one-cycle pulse.
                wb_daq_csr_byte_reg #(.dw(dw), .WMASK(CH_CTRL_WMASK)) u_ctrl (
                    .i_clk (wb_clk),
                    .i_rst (wb_rst),
                    .i_we  (w_ctrl_we),
                    .i_sel (wb.wb_sel_i),
                    .i_dat (wb.wb_dat_i),
                    .o_q   (daq_channel_control_reg[n*dw +: dw])
                );

                assign w_start[n]   = w_ctrl_we & wb.wb_sel_i[0] & wb.wb_dat_i[CHCTRL_START_BIT];
                assign w_ch_addr[n] = daq_channel_address_reg[n*dw +: dw];
                assign w_ch_ctrl[n] = daq_channel_control_reg[n*dw +: dw];
                assign w_ch_stat[n] = daq_channel_status_reg[n*dw +: dw];
            end else begin : g_off
                assign w_ch_addr[n] = '0;
                assign w_ch_ctrl[n] = '0;
                assign w_ch_stat[n] = '0;
            end
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            REG_CONTROL:    w_rdata = daq_control_reg;
            REG_IRQ_STATUS: w_rdata = dw'(r_irq_status);
            REG_IRQ_ENABLE: w_rdata = w_irq_en;
            REG_ID:         w_rdata = dw'(id_value(NUM_CHANNELS));
            REG_CH_ADDR:    w_rdata = w_ch_addr[w_ch];
            REG_CH_CTRL:    w_rdata = w_ch_ctrl[w_ch];
            REG_CH_STATUS:  w_rdata = w_ch_stat[w_ch];
            default:        w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_dat        <= '0;
            r_irq_status <= '0;
            r_start      <= '0;
            r_interrupt  <= 1'b0;
        end else begin
            r_ack        <= w_access & ~w_bad;
            r_err        <= w_access & w_bad;
            r_dat        <= (w_access & ~w_bad) ? w_rdata : '0;
            r_irq_status <= (r_irq_status & ~w_w1c) | daq_channel_event;
            r_start      <= w_start;
            r_interrupt  <= daq_control_reg[CTRL_IRQ_EN_BIT] &
                            (|(r_irq_status & w_irq_en[NUM_CHANNELS-1:0]));
        end
    end

    assign wb.wb_dat_o        = r_dat;
    assign wb.wb_ack_o        = r_ack;
    assign wb.wb_err_o        = r_err;
    assign wb.wb_rty_o        = 1'b0;
    assign daq_channel_start  = r_start;
    assign interrupt          = r_interrupt;

    assign w_unused = ^{wb.wb_cti_i, wb.wb_bte_i, wb.wb_adr_i[1:0]};

endmodule

// File: tb/tb_wb_daq_csr_array.sv
// tb/tb_wb_daq_csr_array.sv - self-checking bench for wb_daq_csr_array
module tb_wb_daq_csr_array;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int NCH = 4;
`ifdef WB_DAQ_CSR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_daq_csr_array_if #(.dw(DW), .aw(AW)) bus ();

    logic [DW-1:0]     ctrl_o;
    logic [NCH*DW-1:0] ch_addr_o;
    logic [NCH*DW-1:0] ch_ctrl_o;
    logic [NCH*DW-1:0] ch_stat_i;
    logic [NCH-1:0]    start_o;
    logic [NCH-1:0]    ev_i;
    logic              irq_o;

    wb_daq_csr_array #(.dw(DW), .aw(AW), .NUM_CHANNELS(NCH)) dut (
        .wb_clk                  (clk),
        .wb_rst                  (rst),
        .wb                      (bus),
        .daq_control_reg         (ctrl_o),
        .daq_channel_address_reg (ch_addr_o),
        .daq_channel_control_reg (ch_ctrl_o),
        .daq_channel_start       (start_o),
        .daq_channel_status_reg  (ch_stat_i),
        .daq_channel_event       (ev_i),
        .interrupt               (irq_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0]    m_ctrl;
    logic [31:0]    m_irq_en;
    logic [NCH-1:0] m_irq_st;
    logic [31:0]    m_ch_addr [NCH];
    logic [31:0]    m_ch_ctrl [NCH];
    logic [31:0]    m_ch_stat [NCH];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic exp_irq();
        return m_ctrl[0] & (|(m_irq_st & m_irq_en[NCH-1:0]));
    endfunction

    task automatic mdl_reset();
        m_ctrl   = '0;
        m_irq_en = '0;
        m_irq_st = '0;
        for (int c = 0; c < NCH; c++) begin
            m_ch_addr[c] = '0;
            m_ch_ctrl[c] = '0;
        end
    endtask

    // Reference behaviour of one bus access plus the events seen in that cycle.
    task automatic mdl_access(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                              input logic we, input logic [NCH-1:0] ev,
                              output logic [31:0] e_dat, output logic e_ack, output logic e_err,
                              output logic [NCH-1:0] e_start);
        int off, blk, w, ch;
        bit mapped, ro, bad;
        logic [31:0] rd;
        off = int'(adr) & 32'hFC;
        blk = off >> 4;
        w   = (off >> 2) & 3;
        ch  = blk - 1;
        rd = '0; mapped = 1'b1; ro = 1'b0;
        if (blk == 0) begin
            case (w)
                0: rd = m_ctrl;
                1: rd = 32'(m_irq_st);
                2: rd = m_irq_en;
                default: begin rd = 32'hDA02_0000 | NCH; ro = 1'b1; end
            endcase
        end else if (blk <= NCH) begin
            case (w)
                0: rd = m_ch_addr[ch];
                1: rd = m_ch_ctrl[ch];
                2: begin rd = m_ch_stat[ch]; ro = 1'b1; end
                default: mapped = 1'b0;
            endcase
        end else begin
            mapped = 1'b0;
        end
        if (!mapped) rd = '0;
        bad     = ERR_EN && (!mapped || (we && ro));
        e_ack   = !bad;
        e_err   = bad;
        e_dat   = bad ? 32'h0 : rd;
        e_start = '0;
        if (we && !bad) begin
            if (blk == 0 && w == 0) m_ctrl = merge(m_ctrl, dat, sel);
            if (blk == 0 && w == 1 && sel[0]) m_irq_st = m_irq_st & ~dat[NCH-1:0];
            if (blk == 0 && w == 2) m_irq_en = merge(m_irq_en, dat, sel) & 32'((1 << NCH) - 1);
            if (blk >= 1 && blk <= NCH && w == 0) m_ch_addr[ch] = merge(m_ch_addr[ch], dat, sel);
            if (blk >= 1 && blk <= NCH && w == 1) begin
                m_ch_ctrl[ch] = merge(m_ch_ctrl[ch], dat, sel) & ~32'h1;
                if (sel[0] && dat[0]) e_start[ch] = 1'b1;
            end
        end
        m_irq_st = m_irq_st | ev;
    endtask

    task automatic chk_regs(input string tag);
        logic [NCH*DW-1:0] ea, ec;
        for (int c = 0; c < NCH; c++) begin
            ea[c*DW +: DW] = m_ch_addr[c];
            ec[c*DW +: DW] = m_ch_ctrl[c];
        end
        chk({tag, " control_reg"}, 128'(ctrl_o), 128'(m_ctrl));
        chk({tag, " chan_addr"}, 128'(ch_addr_o), 128'(ea));
        chk({tag, " chan_ctrl"}, 128'(ch_ctrl_o), 128'(ec));
        chk({tag, " interrupt"}, 128'(irq_o), 128'(exp_irq()));
    endtask

    task automatic xfer(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic we, input logic [NCH-1:0] ev, input string tag,
                        output logic [31:0] rdata);
        logic [31:0]    e_dat;
        logic           e_ack, e_err;
        logic [NCH-1:0] e_start;
        @(negedge clk);
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_we_i  = we;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        ev_i         = ev;
        mdl_access(adr, dat, sel, we, ev, e_dat, e_ack, e_err, e_start);
        @(negedge clk);
        ev_i = '0;
        chk({tag, " ack"}, 128'(bus.wb_ack_o), 128'(e_ack));
        chk({tag, " err"}, 128'(bus.wb_err_o), 128'(e_err));
        if (!we) chk({tag, " rdata"}, 128'(bus.wb_dat_o), 128'(e_dat));
        chk({tag, " start"}, 128'(start_o), 128'(e_start));
        rdata = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        @(negedge clk);
        chk({tag, " ack drop"}, 128'({bus.wb_ack_o, bus.wb_err_o}), 128'(2'b00));
        chk({tag, " start drop"}, 128'(start_o), 128'(0));
        chk_regs(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  adr;
        logic [NCH-1:0] ev;

        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0; bus.wb_we_i = 1'b0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_cti_i = '0; bus.wb_bte_i = '0;
        ev_i = '0;
        for (int c = 0; c < NCH; c++) begin
            m_ch_stat[c] = $urandom;
            ch_stat_i[c*DW +: DW] = m_ch_stat[c];
        end
        mdl_reset();

        repeat (3) @(negedge clk);
        chk("reset ack/err/rty", 128'({bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o}), 128'(3'b000));
        chk("reset dat_o", 128'(bus.wb_dat_o), 128'(0));
        chk("reset start", 128'(start_o), 128'(0));
        chk_regs("reset");
        rst = 1'b0;

        xfer(8'h10, 32'h12345678, 4'b0011, 1'b1, '0, "ch0 addr wr", rd);
        xfer(8'h10, 32'h0, 4'b1111, 1'b0, '0, "ch0 addr rd", rd);
        chk("ch0 addr lanes", 128'(rd), 128'(32'h00005678));

        xfer(8'h24, 32'h1, 4'b1111, 1'b1, '0, "ch1 start wr", rd);
        xfer(8'h24, 32'h0, 4'b1111, 1'b0, '0, "ch1 ctrl rd", rd);
        chk("ch1 ctrl self-clear", 128'(rd), 128'(0));

        xfer(8'h0C, 32'h0, 4'b1111, 1'b0, '0, "id rd", rd);
        chk("id value", 128'(rd), 128'(32'hDA020004));
        xfer(8'hFC, 32'h0, 4'b1111, 1'b0, '0, "unmapped rd", rd);
        chk("unmapped value", 128'(rd), 128'(0));

        @(negedge clk);
        bus.wb_adr_i = 8'h0C; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("held strobe ack %0d", i), 128'(bus.wb_ack_o), 128'(i % 2 == 0));
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        @(negedge clk);

        xfer(8'h00, 32'h1, 4'b1111, 1'b1, '0, "control wr", rd);
        xfer(8'h08, 32'h4, 4'b1111, 1'b1, '0, "irq_en wr", rd);
        @(negedge clk);
        ev_i = 4'b0100;
        @(negedge clk);
        ev_i = '0;
        m_irq_st = m_irq_st | 4'b0100;
        chk("irq not yet", 128'(irq_o), 128'(0));
        @(negedge clk);
        chk("irq one cycle later", 128'(irq_o), 128'(1));
        xfer(8'h04, 32'h4, 4'b1111, 1'b1, '0, "irq w1c", rd);
        chk("irq cleared", 128'(irq_o), 128'(0));

        @(negedge clk);
        ev_i = 4'b0010;
        @(negedge clk);
        ev_i = '0;
        m_irq_st = m_irq_st | 4'b0010;
        xfer(8'h04, 32'h2, 4'b0001, 1'b1, 4'b0010, "set vs clear", rd);
        xfer(8'h04, 32'h0, 4'b1111, 1'b0, '0, "irq_st rd", rd);
        chk("set wins", 128'(rd[1]), 128'(1));

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) adr = 8'($urandom_range(0, 255));
            else adr = 8'($urandom_range(0, 16 * (NCH + 1) - 1));
            ev = ($urandom_range(0, 3) == 0) ? NCH'($urandom_range(0, 15)) : '0;
            xfer(adr, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ev,
                 $sformatf("rnd%0d @%0h", i, adr), rd);
        end

        xfer(8'h00, 32'hA5A5A5A5, 4'b1111, 1'b1, '0, "pre-reset ctrl", rd);
        @(negedge clk);
        bus.wb_adr_i = 8'h00; bus.wb_dat_i = 32'h5A5A5A5A; bus.wb_sel_i = 4'b1111;
        bus.wb_we_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        ev_i = 4'b1111;
        rst  = 1'b1;
        @(negedge clk);
        mdl_reset();
        chk("reset abort ack", 128'({bus.wb_ack_o, bus.wb_err_o}), 128'(2'b00));
        chk("reset abort ctrl", 128'(ctrl_o), 128'(0));
        rst = 1'b0;
        ev_i = '0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        @(negedge clk);
        chk("post-reset ack", 128'(bus.wb_ack_o), 128'(0));
        xfer(8'h00, 32'h0, 4'b1111, 1'b0, '0, "post-reset ctrl rd", rd);
        chk("post-reset ctrl value", 128'(rd), 128'(0));
        xfer(8'h04, 32'h0, 4'b1111, 1'b0, '0, "post-reset irq_st rd", rd);
        chk("events dropped in reset", 128'(rd), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_daq_csr_array.md
WB_DAQ_CSR_ARRAY -- requirements
Module: wb_daq_csr_array

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  dw  32  data width.
  aw  8  byte address width.
  NUM_CHANNELS  4  channel count, legal range 1..8.
REQ-002 SHALL have ports (name  direction  width  meaning), one per line:
  wb_clk  in  1  single clock.
  wb_rst  in  1  reset, synchronous, active-high.
  wb_adr_i  in  aw  byte address; bits [1:0] ignored.
  wb_dat_i  in  dw  write data.
  wb_sel_i  in  4  byte enables.
  wb_we_i  in  1  write strobe.
  wb_cyc_i  in  1  bus cycle.
  wb_stb_i  in  1  strobe.
  wb_cti_i  in  3  ignored.
  wb_bte_i  in  2  ignored.
  wb_dat_o  out  dw  read data.
  wb_ack_o  out  1  acknowledge.
  wb_err_o  out  1  error.
  wb_rty_o  out  1  retry, tied 0.
  daq_control_reg  out  dw  global control.
  daq_channel_address_reg  out  NUM_CHANNELS*dw  per-channel address, channel n at [n*dw +: dw].
  daq_channel_control_reg  out  NUM_CHANNELS*dw  per-channel control, same packing.
  daq_channel_start  out  NUM_CHANNELS  one-cycle start pulses.
  daq_channel_status_reg  in  NUM_CHANNELS*dw  per-channel status, read-only.
  daq_channel_event  in  NUM_CHANNELS  event pulses.
  interrupt  out  1  registered interrupt request.

Function
REQ-003 Address map (byte offsets) SHALL be:
  0x00 CONTROL (RW).
  0x04 IRQ_STATUS (W1C, [NUM_CHANNELS-1:0]).
  0x08 IRQ_ENABLE (RW, [NUM_CHANNELS-1:0]).
  0x0C ID (RO) = {16'hDA02, 8'd0, NUM_CHANNELS[7:0]}.
  Channel n at 0x10+n*0x10: +0x0 ADDRESS (RW), +0x4 CONTROL (RW), +0x8 STATUS (RO), +0xC reserved.
REQ-004 Access = wb_cyc_i & wb_stb_i & ~wb_ack_o. wb_ack_o SHALL pulse exactly one cycle, the cycle after the access; a held strobe acks every second cycle.
REQ-005 Writes SHALL take effect on the access cycle, per byte lane enabled by wb_sel_i. Writes to RO or reserved offsets SHALL have no effect.
REQ-006 Read data SHALL be registered and valid with wb_ack_o. Unmapped or reserved offsets SHALL read 0.
REQ-007 Writing channel CONTROL with bit0=1 (lane 0 enabled) SHALL pulse daq_channel_start[n] for one cycle, the cycle after the access. Stored bit0 SHALL self-clear and always reads 0.
REQ-008 IRQ_STATUS[n] SHALL set on daq_channel_event[n]=1 and clear on a write of 1 to that bit. Set and clear in the same cycle: set wins.
REQ-009 interrupt SHALL be registered: interrupt <= daq_control_reg[0] & |(IRQ_STATUS & IRQ_ENABLE). Latency is one cycle from the state change.
REQ-010 Channel bits >= NUM_CHANNELS SHALL read 0 and ignore writes.

Reset
REQ-011 On wb_rst=1 at a clock edge, SHALL zero every register and every output: wb_dat_o, wb_ack_o, wb_err_o, daq_control_reg, all channel registers, IRQ_STATUS, IRQ_ENABLE, daq_channel_start, interrupt.
REQ-012 Reset asserted mid-access SHALL abort the access: no ack, no write.
REQ-013 Events arriving during reset SHALL be dropped.

Configuration
REQ-014 Macro WB_DAQ_CSR_ERR_EN: when defined, an access to an unmapped or reserved offset, or a write to an RO offset, SHALL return wb_err_o instead of wb_ack_o (same timing, one cycle), with wb_dat_o=0 and no side effects. When undefined, wb_err_o is tied 0 and such accesses are acked per REQ-005/006.

Structure
REQ-015 Shared package/include wb_daq_csr_array_include.vh SHALL hold all offset constants, the ID value, and the CONTROL bit positions.
REQ-016 Sub-module wb_daq_csr_byte_reg (one dw-bit byte-enabled RW register) SHALL be instantiated per RW register.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
  - Write 0x12345678 to 0x10 with sel=4'b0011, then read 0x10 -> 0x00005678, ack one cycle after each strobe.
  - Write 0x1 to 0x24 -> daq_channel_start=4'b0010 for exactly one cycle; read 0x24 -> 0.
  - CONTROL=1, IRQ_ENABLE=0x4, pulse event[2] -> interrupt=1 one cycle later; write 0x4 to 0x04 -> interrupt=0.
  - event[1] pulses in the same cycle as a W1C 0x2 -> IRQ_STATUS[1] stays 1.
  - Read 0x0C with NUM_CHANNELS=4 -> 0xDA020004; read 0xFC -> 0, ack (err with WB_DAQ_CSR_ERR_EN defined).
  - wb_rst asserted during a write to 0x00 -> no ack; read after reset -> 0.
